// File: rtl/dsm_decimator.sv
// Sinc1 decimator for a 1-bit delta-sigma stream: counts ones over windows of
// 2^DATA_WIDTH accepted bits and presents each result on a valid/ready register.
module dsm_decimator #(
    parameter int DATA_WIDTH   = 8,
    parameter int SKIP_WINDOWS = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  ovr_o
);

    localparam int SKIP_W = (SKIP_WINDOWS < 2) ? 1 : $clog2(SKIP_WINDOWS + 1);

    typedef enum logic {
        ST_SKIP,
        ST_RUN
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] bit_cnt;
    logic [DATA_WIDTH:0]   ones_acc;
    logic [SKIP_W-1:0]     skip_cnt;

    logic                  window_end;
    logic [DATA_WIDTH:0]   final_cnt;
    logic [DATA_WIDTH-1:0] sample_sat;

    always_comb begin
        window_end = en_i && (bit_cnt == '1);
        final_cnt  = ones_acc + (DATA_WIDTH + 1)'(data_i);
        // Only a window of all ones reaches 2^DATA_WIDTH; it clips to full scale.
        sample_sat = final_cnt[DATA_WIDTH] ? '1 : final_cnt[DATA_WIDTH-1:0];
    end

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, including valid_o in the overrun test.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= (SKIP_WINDOWS == 0) ? ST_RUN : ST_SKIP;
            bit_cnt  <= '0;
            ones_acc <= '0;
            skip_cnt <= SKIP_W'(SKIP_WINDOWS);
            data_o   <= '0;
            valid_o  <= 1'b0;
            ovr_o    <= 1'b0;
        end else begin
            ovr_o <= 1'b0;

            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            if (en_i) begin
                bit_cnt  <= bit_cnt + 1'b1;
                ones_acc <= window_end ? '0 : final_cnt;
            end

            if (window_end) begin
                case (state)
                    ST_SKIP: begin
                        skip_cnt <= skip_cnt - 1'b1;
                        if (skip_cnt == SKIP_W'(1)) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        data_o  <= sample_sat;
                        valid_o <= 1'b1;
                        // Overwriting an undelivered sample is an overrun unless
                        // the consumer takes it on this very edge.
                        ovr_o   <= valid_o && !ready_i;
                    end
                    default: state <= ST_SKIP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsm_decimator.sv
// Directed self-checking bench for dsm_decimator (DATA_WIDTH=8, SKIP_WINDOWS=1).
module tb_dsm_decimator;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       en_i;
    logic       data_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       ovr_o;

    int checks = 0;
    int errors = 0;
    int dsm_acc = 0;
    int vcnt;
    int ocnt;

    dsm_decimator #(
        .DATA_WIDTH  (8),
        .SKIP_WINDOWS(1)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .data_i (data_i),
        .data_o (data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .ovr_o  (ovr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given bit strobe; outputs sampled 1 time unit after the edge.
    task automatic cycle(input logic en, input logic d);
        en_i   = en;
        data_i = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_n(input int n, input logic d, output int v, output int o);
        v = 0;
        o = 0;
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, d);
            v += int'(valid_o);
            o += int'(ovr_o);
        end
    endtask

    // Bench-side first-order delta-sigma modulator standing in for the DAC core.
    task automatic send_dsm(input int x, output int v, output int o);
        int s;
        v = 0;
        o = 0;
        for (int i = 0; i < 256; i++) begin
            s       = dsm_acc + x;
            dsm_acc = s % 256;
            cycle(1'b1, s >= 256);
            v += int'(valid_o);
            o += int'(ovr_o);
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        en_i    = 1'b0;
        data_i  = 1'b0;
        ready_i = 1'b0;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("reset_data", 32'(data_o), 32'd0);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_ovr", 32'(ovr_o), 32'd0);
        rst_ni  = 1'b1;
        ready_i = 1'b1;

        // All zeros: skip window silent, then one zero sample per window.
        send_n(256, 1'b0, vcnt, ocnt);
        check("zeros_skip_no_valid", 32'(vcnt), 32'd0);
        send_n(255, 1'b0, vcnt, ocnt);
        check("zeros_pre_end_no_valid", 32'(vcnt), 32'd0);
        send_n(1, 1'b0, vcnt, ocnt);
        check("zeros_first_valid", 32'(valid_o), 32'd1);
        check("zeros_first_data", 32'(data_o), 32'd0);
        send_n(256, 1'b0, vcnt, ocnt);
        check("zeros_one_pulse_per_window", 32'(vcnt), 32'd1);
        check("zeros_second_data", 32'(data_o), 32'd0);

        // All ones: 256 saturates to 0xFF, never an overrun.
        send_n(256, 1'b1, vcnt, ocnt);
        check("ones_pulses", 32'(vcnt), 32'd1);
        check("ones_no_ovr", 32'(ocnt), 32'd0);
        check("ones_saturated", 32'(data_o), 32'hFF);
        send_n(256, 1'b1, vcnt, ocnt);
        check("ones_saturated_again", 32'(data_o), 32'hFF);

        // Modulator loopback reproduces the input code exactly.
        send_dsm(100, vcnt, ocnt);
        check("dsm100_valid", 32'(valid_o), 32'd1);
        check("dsm100_data", 32'(data_o), 32'd100);
        send_dsm(100, vcnt, ocnt);
        check("dsm100_data_again", 32'(data_o), 32'd100);
        send_dsm(37, vcnt, ocnt);
        send_dsm(37, vcnt, ocnt);
        check("dsm37_data", 32'(data_o), 32'd37);
        check("dsm37_no_ovr", 32'(ocnt), 32'd0);

        // Strobed input, accepted pattern 1,0,1,1: 192 per 512-clock window.
        vcnt = 0;
        for (int i = 0; i < 255; i++) begin
            cycle(1'b1, (i % 4) != 1);
            vcnt += int'(valid_o);
            cycle(1'b0, 1'b0);
            vcnt += int'(valid_o);
        end
        check("gap_no_early_valid", 32'(vcnt), 32'd0);
        cycle(1'b1, 1'b1);
        check("gap_latency_valid", 32'(valid_o), 32'd1);
        check("gap_data", 32'(data_o), 32'd192);
        cycle(1'b0, 1'b0);
        check("gap_ready_clears", 32'(valid_o), 32'd0);

        // Overrun: ready held low across two window ends.
        ready_i = 1'b0;
        send_n(10, 1'b1, vcnt, ocnt);
        send_n(246, 1'b0, vcnt, ocnt);
        check("ovr_first_valid", 32'(valid_o), 32'd1);
        check("ovr_first_data", 32'(data_o), 32'd10);
        check("ovr_first_no_ovr", 32'(ovr_o), 32'd0);
        send_n(20, 1'b1, vcnt, ocnt);
        check("ovr_data_held", 32'(data_o), 32'd10);
        send_n(235, 1'b0, vcnt, ocnt);
        check("ovr_quiet_mid_window", 32'(ocnt), 32'd0);
        send_n(1, 1'b0, vcnt, ocnt);
        check("ovr_pulse", 32'(ovr_o), 32'd1);
        check("ovr_overwritten", 32'(data_o), 32'd20);
        check("ovr_valid_kept", 32'(valid_o), 32'd1);
        cycle(1'b0, 1'b0);
        check("ovr_one_cycle", 32'(ovr_o), 32'd0);
        check("ovr_valid_still", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        cycle(1'b0, 1'b0);
        check("ovr_ready_clears", 32'(valid_o), 32'd0);

        // Window end on the accept edge: new sample loads, no overrun.
        ready_i = 1'b0;
        send_n(5, 1'b1, vcnt, ocnt);
        send_n(251, 1'b0, vcnt, ocnt);
        check("coinc_first_data", 32'(data_o), 32'd5);
        send_n(7, 1'b1, vcnt, ocnt);
        send_n(248, 1'b0, vcnt, ocnt);
        ready_i = 1'b1;
        send_n(1, 1'b0, vcnt, ocnt);
        check("coinc_valid", 32'(valid_o), 32'd1);
        check("coinc_data", 32'(data_o), 32'd7);
        check("coinc_no_ovr", 32'(ovr_o), 32'd0);
        ready_i = 1'b0;

        // Reset at bit 130 of a window: partial lost, skip window restarts.
        send_n(130, 1'b1, vcnt, ocnt);
        rst_ni = 1'b0;
        cycle(1'b1, 1'b1);
        check("midrst_data", 32'(data_o), 32'd0);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_ovr", 32'(ovr_o), 32'd0);
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        send_n(256, 1'b1, vcnt, ocnt);
        check("midrst_skip_silent", 32'(vcnt), 32'd0);
        send_n(50, 1'b1, vcnt, ocnt);
        ocnt = vcnt;
        send_n(205, 1'b0, vcnt, ocnt);
        check("midrst_run_silent", 32'(vcnt + ocnt), 32'd0);
        send_n(1, 1'b0, vcnt, ocnt);
        check("midrst_valid_after_512", 32'(valid_o), 32'd1);
        check("midrst_data_after", 32'(data_o), 32'd50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
